data_mem_arbiter: RTL and testbench

Two-port arbiter and owner of the 32×8 data memory used by the 8-bit microprocessor's load/store instructions. It serialises accesses from the CPU load/store port and a debug/loader port (board switches or a host), one access at a time. Each requester uses a req/ack handshake. The block also restores the fixed power-on memory image on reset.

---
 rtl/data_mem_arb_pkg.sv | 30 +++
 rtl/data_mem_core.sv | 46 ++++
 rtl/data_mem_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_data_mem_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_arb_pkg.sv
// data_mem_arb_pkg
// Shared definitions for the data memory arbiter and its memory core:
// arbiter state encoding, owner constants, default widths and the
// function that produces the power-on memory image.
// Ports: none (package).
package data_mem_arb_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 5;
    localparam int HALF_DEPTH = 2 ** (ADDR_W_DEF - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE   = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DBG = 1'b1;

    // Power-on image: the lower half counts up from zero, the upper half
    // counts down from zero in two's complement (mem[16+k] = -k).
    function automatic logic [DATA_W_DEF-1:0] reset_image(input int idx);
        if (idx < HALF_DEPTH) begin
            return DATA_W_DEF'(idx);
        end
        return DATA_W_DEF'(HALF_DEPTH - idx);
    endfunction

endpackage

// File: rtl/data_mem_core.sv
// data_mem_core
// Single-port 32x8 data memory: synchronous write, registered read and an
// asynchronous reload of the fixed power-on image while reset is low.
// Ports:
//   oscillator - clock, rising edge
//   reset      - asynchronous active-low reset (reloads the image)
//   we         - write enable
//   addr       - read/write address
//   wdata      - write data
//   rdata      - registered read data (mem[addr] sampled at the last edge)
module data_mem_core
    import data_mem_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              oscillator,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // The array is built from flops so that reset can restore the whole
    // image at once; any write in flight when reset falls is simply lost.
    // The read register samples the pre-write contents every cycle.
    always_ff @(posedge oscillator or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= DATA_W'(reset_image(i));
            end
            rdata <= '0;
        end else begin
            if (we) begin
                mem[addr] <= wdata;
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter
// Two-port arbiter that owns the data memory. Serialises CPU load/store
// accesses and debug/loader accesses, one at a time, each with a req/ack
// handshake. Sequence per access: IDLE latches the winner, SERVE performs
// the access, RELEASE presents the one-cycle ack.
// Configuration macro: DATA_MEM_ARB_ROUND_ROBIN_EN
//   defined   - ties go to the port that did not win last (CPU first)
//   undefined - fixed priority, CPU always wins ties
// Ports:
//   oscillator, reset           - clock (rising) and async active-low reset
//   cpu_req/we/addr/wdata       - CPU request fields
//   cpu_ack, cpu_rdata          - CPU completion pulse and load result
//   dbg_req/we/addr/wdata       - debug port request fields
//   dbg_ack, dbg_rdata          - debug completion pulse and load result
//   busy                        - high whenever the FSM is not in IDLE
//   owner                       - port being served (0 = CPU, 1 = DBG)
module data_mem_arbiter
    import data_mem_arb_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
) (
    input  logic              oscillator,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              busy,
    output logic              owner
);

    arb_state_t        state_q;
    arb_state_t        state_d;
    logic              latch_en;
    logic              do_access;
    logic              any_req;
    logic              grant_dbg;
    logic              win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;

`ifdef DATA_MEM_ARB_ROUND_ROBIN_EN
    logic              last_win;

    // Remember who won the most recent grant so a tie goes to the other
    // port. Starts at DBG so the CPU takes the very first tie.
    always_ff @(posedge oscillator or negedge reset) begin
        if (!reset) begin
            last_win <= OWN_DBG;
        end else if (latch_en) begin
            last_win <= grant_dbg ? OWN_DBG : OWN_CPU;
        end
    end

    // A lone requester always wins; on a tie DBG only wins if CPU won last.
    always_comb begin
        grant_dbg = dbg_req && (!cpu_req || (last_win == OWN_CPU));
    end
`else
    // Fixed priority: DBG is only granted when the CPU is not asking.
    always_comb begin
        grant_dbg = !cpu_req;
    end
`endif

    // Select the winning port's request fields for latching in IDLE.
    always_comb begin
        any_req   = cpu_req || dbg_req;
        win_we    = grant_dbg ? dbg_we    : cpu_we;
        win_addr  = grant_dbg ? dbg_addr  : cpu_addr;
        win_wdata = grant_dbg ? dbg_wdata : cpu_wdata;
    end

    // State register.
    always_ff @(posedge oscillator or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: latch in IDLE, access in SERVE, ack in RELEASE.
    always_comb begin
        state_d   = state_q;
        latch_en  = 1'b0;
        do_access = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    latch_en = 1'b1;
                    state_d  = SERVE;
                end
            end
            SERVE: begin
                do_access = 1'b1;
                state_d   = RELEASE;
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The memory read register is pointed at the winner's address while
    // still in IDLE, so the word is already sitting in it when SERVE ends
    // and the load can be captured on the same edge as the store would be.
    always_comb begin
        mem_addr = (state_q == IDLE) ? win_addr : lat_addr;
        mem_we   = do_access && lat_we;
    end

    data_mem_core #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_core (
        .oscillator (oscillator),
        .reset      (reset),
        .we         (mem_we),
        .addr       (mem_addr),
        .wdata      (lat_wdata),
        .rdata      (mem_rdata)
    );

    // Latch registers, owner, per-port ack pulses and load results. Acks
    // default low every cycle so each one lives exactly for RELEASE.
    always_ff @(posedge oscillator or negedge reset) begin
        if (!reset) begin
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            owner     <= OWN_DBG;
            busy      <= 1'b0;
            cpu_ack   <= 1'b0;
            dbg_ack   <= 1'b0;
            cpu_rdata <= '0;
            dbg_rdata <= '0;
        end else begin
            busy    <= (state_d != IDLE);
            cpu_ack <= 1'b0;
            dbg_ack <= 1'b0;
            if (latch_en) begin
                lat_we    <= win_we;
                lat_addr  <= win_addr;
                lat_wdata <= win_wdata;
                owner     <= grant_dbg ? OWN_DBG : OWN_CPU;
            end
            if (do_access) begin
                if (owner == OWN_DBG) begin
                    dbg_ack <= 1'b1;
                    if (!lat_we) begin
                        dbg_rdata <= mem_rdata;
                    end
                end else begin
                    cpu_ack <= 1'b1;
                    if (!lat_we) begin
                        cpu_rdata <= mem_rdata;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter
// Scoreboard bench for data_mem_arbiter: accesses push their expected
// completion (port and load data from a reference memory) into a queue;
// a monitor pops and compares on every ack.
`timescale 1ns/1ps
module tb_data_mem_arbiter;

    logic       oscillator = 1'b0;
    logic       reset      = 1'b0;
    logic       cpu_req    = 1'b0;
    logic       cpu_we     = 1'b0;
    logic [4:0] cpu_addr   = '0;
    logic [7:0] cpu_wdata  = '0;
    logic       cpu_ack;
    logic [7:0] cpu_rdata;
    logic       dbg_req    = 1'b0;
    logic       dbg_we     = 1'b0;
    logic [4:0] dbg_addr   = '0;
    logic [7:0] dbg_wdata  = '0;
    logic       dbg_ack;
    logic [7:0] dbg_rdata;
    logic       busy;
    logic       owner;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit         port;
        bit         we;
        logic [7:0] data;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] ref_mem [32];
    bit         prev_ack = 1'b0;

    data_mem_arbiter #(.DATA_W(8), .ADDR_W(5)) dut (
        .oscillator (oscillator),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_ack    (cpu_ack),
        .cpu_rdata  (cpu_rdata),
        .dbg_req    (dbg_req),
        .dbg_we     (dbg_we),
        .dbg_addr   (dbg_addr),
        .dbg_wdata  (dbg_wdata),
        .dbg_ack    (dbg_ack),
        .dbg_rdata  (dbg_rdata),
        .busy       (busy),
        .owner      (owner)
    );

    always #5 oscillator = ~oscillator;

    // Reference memory image: 0..15 count up, 16+k holds -k.
    task automatic refReset();
        for (int i = 0; i < 16; i++) begin
            ref_mem[i]      = 8'(i);
            ref_mem[16 + i] = 8'((256 - i) % 256);
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every ack must match the oldest expected completion.
    always @(negedge oscillator) begin : monitor
        exp_t e;
        if (cpu_ack || dbg_ack) begin
            checkOutput("ack_exclusive", 32'(cpu_ack & dbg_ack), 0);
            checkOutput("ack_one_cycle", 32'(prev_ack), 0);
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("[TB] FAIL unexpected_ack: cpu_ack=%0b dbg_ack=%0b, expected none", cpu_ack, dbg_ack);
            end else begin
                e = sb.pop_front();
                checkOutput("ack_port", 32'(dbg_ack), 32'(e.port));
                checkOutput("owner", 32'(owner), 32'(e.port));
                if (!e.we) begin
                    checkOutput("rdata", 32'(e.port ? dbg_rdata : cpu_rdata), 32'(e.data));
                end
            end
        end
        prev_ack = cpu_ack || dbg_ack;
    end

    // One complete access on one port, starting and ending at a falling
    // edge with the arbiter idle. Request fields are scrambled once the
    // request has been latched to show they no longer matter.
    task automatic applyStimulus(input bit port, input bit we, input logic [4:0] addr, input logic [7:0] wdata);
        exp_t e;
        int   waited;
        bit   got;
        e.port = port;
        e.we   = we;
        e.data = we ? wdata : ref_mem[addr];
        if (we) ref_mem[addr] = wdata;
        sb.push_back(e);
        if (port) begin
            dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata;
        end else begin
            cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        end
        waited = 0;
        got    = 1'b0;
        while (!got && waited < 10) begin
            @(negedge oscillator);
            waited++;
            if (waited <= 2) checkOutput("busy_active", 32'(busy), 1);
            if (waited == 1) begin
                if (port) begin
                    dbg_we = 1'($urandom); dbg_addr = 5'($urandom); dbg_wdata = 8'($urandom);
                end else begin
                    cpu_we = 1'($urandom); cpu_addr = 5'($urandom); cpu_wdata = 8'($urandom);
                end
            end
            got = port ? dbg_ack : cpu_ack;
        end
        checkOutput("ack_latency", 32'(waited), 2);
        cpu_req = 1'b0;
        dbg_req = 1'b0;
        @(negedge oscillator);
        checkOutput("busy_idle", 32'(busy), 0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        int n_tie;
        int acks;
        int cyc;
        bit got;
        exp_t e;

        refReset();
        repeat (2) @(negedge oscillator);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_owner", 32'(owner), 1);
        checkOutput("rst_acks", 32'({cpu_ack, dbg_ack}), 0);
        checkOutput("rst_rdata", 32'({cpu_rdata, dbg_rdata}), 0);
        reset = 1'b1;
        @(negedge oscillator);

        $display("[TB] directed accesses");
        applyStimulus(1'b1, 1'b0, 5'd17, 8'h00);
        applyStimulus(1'b0, 1'b1, 5'd3, 8'h5A);
        applyStimulus(1'b0, 1'b0, 5'd3, 8'h00);
        applyStimulus(1'b0, 1'b0, 5'd4, 8'h00);
        applyStimulus(1'b1, 1'b1, 5'd9, 8'h33);
        applyStimulus(1'b0, 1'b0, 5'd9, 8'h00);

        $display("[TB] address wrap");
        applyStimulus(1'b0, 1'b1, 5'd31, 8'hA7);
        applyStimulus(1'b0, 1'b0, 5'd31 + 5'd1, 8'h00);
        applyStimulus(1'b1, 1'b0, 5'd31, 8'h00);

        $display("[TB] random accesses");
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'($urandom), 1'($urandom), 5'($urandom), 8'($urandom));
        end

        $display("[TB] reset during SERVE");
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd31; dbg_wdata = 8'h00;
        @(negedge oscillator);
        reset   = 1'b0;
        dbg_req = 1'b0;
        repeat (3) begin
            @(negedge oscillator);
            checkOutput("rst_no_ack", 32'(cpu_ack | dbg_ack), 0);
        end
        checkOutput("rst_mid_busy", 32'(busy), 0);
        checkOutput("rst_mid_owner", 32'(owner), 1);
        checkOutput("rst_mid_rdata", 32'({cpu_rdata, dbg_rdata}), 0);
        refReset();
        reset = 1'b1;
        @(negedge oscillator);
        applyStimulus(1'b0, 1'b0, 5'd31, 8'h00);
        applyStimulus(1'b1, 1'b0, 5'd17, 8'h00);

        $display("[TB] simultaneous requests");
        reset = 1'b0;
        @(negedge oscillator);
        refReset();
        reset = 1'b1;
        @(negedge oscillator);
        cpu_we = 1'b0; cpu_addr = 5'd5;
        dbg_we = 1'b0; dbg_addr = 5'd20;
`ifdef DATA_MEM_ARB_ROUND_ROBIN_EN
        n_tie = 8;
`else
        n_tie = 10;
`endif
        for (int i = 0; i < n_tie; i++) begin
`ifdef DATA_MEM_ARB_ROUND_ROBIN_EN
            e.port = (i % 2 == 1);
`else
            e.port = 1'b0;
`endif
            e.we   = 1'b0;
            e.data = e.port ? ref_mem[20] : ref_mem[5];
            sb.push_back(e);
        end
        cpu_req = 1'b1;
        dbg_req = 1'b1;
        acks = 0;
        cyc  = 0;
        while (acks < n_tie && cyc < 200) begin
            @(negedge oscillator);
            cyc++;
            if (cpu_ack || dbg_ack) acks++;
        end
        checkOutput("tie_ack_count", 32'(acks), 32'(n_tie));
`ifdef DATA_MEM_ARB_ROUND_ROBIN_EN
        cpu_req = 1'b0;
        dbg_req = 1'b0;
`else
        cpu_req = 1'b0;
        e.port = 1'b1;
        e.we   = 1'b0;
        e.data = ref_mem[20];
        sb.push_back(e);
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 8) begin
            @(negedge oscillator);
            cyc++;
            got = dbg_ack;
        end
        checkOutput("dbg_wait_after_cpu_drop", 32'(cyc), 3);
        dbg_req = 1'b0;
`endif
        repeat (3) @(negedge oscillator);
        checkOutput("scoreboard_empty", 32'(sb.size()), 0);
        checkOutput("final_busy", 32'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
